// File: rtl/cpu_ibus_axi3_bridge.sv
// Single-line instruction buffer bridging the CPU instruction bus onto an AXI3 read port.
// Hits answer in one cycle; a miss refills the whole line with one INCR burst.
module cpu_ibus_axi3_bridge #(
    parameter int BUS_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int ARID       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ibus_read,
    input  logic [31:0]             ibus_vaddr,
    input  logic [31:0]             ibus_paddr,
    input  logic [31:0]             ibus_paddr_plus1,
    input  logic                    ibus_inv,
    input  logic [31:0]             ibus_inv_addr,
    output logic                    ibus_ready,
    output logic                    ibus_valid,
    output logic [DATA_WIDTH-1:0]   ibus_rddata,
    output logic [BUS_WIDTH-1:0]    arid,
    output logic [31:0]             araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [BUS_WIDTH-1:0]    rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [BUS_WIDTH-1:0]    awid,
    output logic [31:0]             awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [BUS_WIDTH-1:0]    wid,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [BUS_WIDTH-1:0]    bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);
    localparam int WORDS    = LINE_WIDTH / DATA_WIDTH;
    localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
    localparam int IDX_BITS = OFF_BITS - 2;
    localparam int TAG_W    = 32 - OFF_BITS;

    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] words [WORDS];
    logic [TAG_W-1:0]      tag;
    logic                  line_valid;
    logic [31:0]           req_addr;
    logic [IDX_BITS-1:0]   beat;

    logic [IDX_BITS-1:0] paddr_idx, req_idx;
    logic [TAG_W-1:0]    paddr_tag, req_tag;
    logic                hit, fill_done, inv_hit;

    assign paddr_idx = ibus_paddr[OFF_BITS-1:2];
    assign paddr_tag = ibus_paddr[31:OFF_BITS];
    assign req_idx   = req_addr[OFF_BITS-1:2];
    assign req_tag   = req_addr[31:OFF_BITS];
    assign hit       = line_valid && (tag == paddr_tag);
    assign fill_done = (state == R) && rvalid && rlast;
    // An invalidate racing the final beat is compared against the tag being installed
    assign inv_hit   = ibus_inv && (ibus_inv_addr[31:OFF_BITS] == (fill_done ? req_tag : tag));

    assign ibus_ready = (state == IDLE);
    assign arid       = BUS_WIDTH'(ARID);
    assign araddr     = {req_tag, {OFF_BITS{1'b0}}};
    assign arlen      = 4'(WORDS - 1);
    assign arsize     = 3'($clog2(DATA_WIDTH / 8));
    assign arburst    = 2'b01;

    assign awid    = '0;
    assign awaddr  = '0;
    assign awlen   = '0;
    assign awsize  = '0;
    assign awburst = '0;
    assign awvalid = 1'b0;
    assign wid     = '0;
    assign wdata   = '0;
    assign wstrb   = '0;
    assign wlast   = 1'b0;
    assign wvalid  = 1'b0;
    assign bready  = 1'b1;

    logic unused_ok;
    assign unused_ok = &{1'b0, ibus_vaddr, ibus_paddr_plus1, ibus_paddr[1:0], ibus_inv_addr[OFF_BITS-1:0],
                         req_addr[1:0], rid, rresp, awready, wready, bid, bresp, bvalid};

    always_ff @(posedge clk) begin
        if (state == R && rvalid)
            words[beat] <= rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            line_valid  <= 1'b0;
            tag         <= '0;
            req_addr    <= '0;
            beat        <= '0;
            ibus_valid  <= 1'b0;
            ibus_rddata <= '0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
        end else begin
            ibus_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ibus_read) begin
                        if (hit) begin
                            ibus_valid  <= 1'b1;
                            ibus_rddata <= words[paddr_idx];
                        end else begin
                            req_addr <= ibus_paddr;
                            arvalid  <= 1'b1;
                            state    <= AR;
                        end
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        beat    <= '0;
                        state   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        beat <= beat + IDX_BITS'(1);
                        if (rlast) begin
                            tag         <= req_tag;
                            line_valid  <= 1'b1;
                            rready      <= 1'b0;
                            ibus_valid  <= 1'b1;
                            // The requested word may be arriving on this very beat
                            ibus_rddata <= (beat == req_idx) ? rdata : words[req_idx];
                            state       <= RESP;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (inv_hit)
                line_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cpu_ibus_axi3_bridge.sv
// Directed bench for cpu_ibus_axi3_bridge: drives the ibus side and plays an AXI3 read slave
// whose memory returns addr ^ 0x12345678 for every word.
module tb_cpu_ibus_axi3_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_read, ibus_inv;
    logic [31:0] ibus_vaddr, ibus_paddr, ibus_paddr_plus1, ibus_inv_addr;
    logic        ibus_ready, ibus_valid;
    logic [31:0] ibus_rddata;
    logic [3:0]  arid, rid, awid, wid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_ibus_axi3_bridge dut (
        .clk(clk), .rst(rst),
        .ibus_read(ibus_read), .ibus_vaddr(ibus_vaddr), .ibus_paddr(ibus_paddr),
        .ibus_paddr_plus1(ibus_paddr_plus1), .ibus_inv(ibus_inv), .ibus_inv_addr(ibus_inv_addr),
        .ibus_ready(ibus_ready), .ibus_valid(ibus_valid), .ibus_rddata(ibus_rddata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [31:0] addr);
        ibus_read  = 1'b1;
        ibus_paddr = addr;
        tick;
        ibus_read  = 1'b0;
    endtask

    // Serve the pending AR for the line at base; leaves time in the RESP cycle
    task automatic do_fill(input logic [31:0] base, input int ar_wait, input bit gap, input bit inv_last);
        check("araddr", araddr, base);
        check("arlen", 32'(arlen), 32'd7);
        check("arsize", 32'(arsize), 32'd2);
        check("arburst", 32'(arburst), 32'd1);
        check("arid", 32'(arid), 32'd0);
        for (int k = 0; k < ar_wait; k++) begin
            tick;
            check("arvalid_hold", 32'(arvalid), 32'd1);
        end
        arready = 1'b1;
        tick;
        arready = 1'b0;
        check("arvalid_drop", 32'(arvalid), 32'd0);
        check("rready_on", 32'(rready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (gap && i > 0) begin
                rvalid = 1'b0;
                tick;
                check("rready_gap", 32'(rready), 32'd1);
            end
            rvalid = 1'b1;
            rdata  = mem_word(base + 32'(4 * i));
            rlast  = (i == 7);
            rresp  = (i == 2) ? 2'b10 : 2'b00;
            if (i == 7 && inv_last) begin
                ibus_inv      = 1'b1;
                ibus_inv_addr = base;
            end
            tick;
        end
        rvalid   = 1'b0;
        rlast    = 1'b0;
        rresp    = 2'b00;
        ibus_inv = 1'b0;
        check("resp_valid", 32'(ibus_valid), 32'd1);
        check("resp_ready", 32'(ibus_ready), 32'd0);
        check("resp_rready", 32'(rready), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ibus_read = 1'b0; ibus_inv = 1'b0;
        ibus_vaddr = '0; ibus_paddr = '0; ibus_paddr_plus1 = '0; ibus_inv_addr = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        tick;
        tick;
        check("rst_ready", 32'(ibus_ready), 32'd1);
        check("rst_valid", 32'(ibus_valid), 32'd0);
        check("rst_rddata", ibus_rddata, 32'd0);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("tie_bready", 32'(bready), 32'd1);
        check("tie_awvalid", 32'(awvalid), 32'd0);
        check("tie_wvalid", 32'(wvalid), 32'd0);
        rst = 1'b0;
        tick;

        // Cold miss at the reset vector
        request(32'hbfc0_0000);
        check("miss_arvalid", 32'(arvalid), 32'd1);
        check("miss_ready", 32'(ibus_ready), 32'd0);
        check("miss_valid", 32'(ibus_valid), 32'd0);
        do_fill(32'hbfc0_0000, 0, 1'b0, 1'b0);
        check("fill0_rddata", ibus_rddata, mem_word(32'hbfc0_0000));
        tick;
        check("after_resp_valid", 32'(ibus_valid), 32'd0);
        check("after_resp_ready", 32'(ibus_ready), 32'd1);

        // Streaming hits on the rest of the line
        ibus_read = 1'b1;
        for (int w = 1; w < 8; w++) begin
            ibus_paddr = 32'hbfc0_0000 + 32'(4 * w);
            tick;
            check("hit_valid", 32'(ibus_valid), 32'd1);
            check("hit_rddata", ibus_rddata, mem_word(32'hbfc0_0000 + 32'(4 * w)));
            check("hit_noar", 32'(arvalid), 32'd0);
        end
        ibus_read = 1'b0;
        tick;
        check("idle_valid", 32'(ibus_valid), 32'd0);
        check("idle_hold", ibus_rddata, mem_word(32'hbfc0_001c));

        // Next line
        request(32'hbfc0_0020);
        check("miss2_arvalid", 32'(arvalid), 32'd1);
        do_fill(32'hbfc0_0020, 0, 1'b0, 1'b0);
        check("fill20_rddata", ibus_rddata, mem_word(32'hbfc0_0020));
        tick;

        // Critical-word offset on a cold line
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        request(32'hbfc0_000c);
        check("crit_arvalid", 32'(arvalid), 32'd1);
        do_fill(32'hbfc0_0000, 0, 1'b0, 1'b0);
        check("crit_rddata", ibus_rddata, mem_word(32'hbfc0_000c));
        tick;

        // Invalidate of another line leaves this one valid
        ibus_inv = 1'b1; ibus_inv_addr = 32'hbfc0_0040;
        tick;
        ibus_inv = 1'b0;
        request(32'hbfc0_0004);
        check("inv_other_hit", 32'(ibus_valid), 32'd1);
        check("inv_other_rddata", ibus_rddata, mem_word(32'hbfc0_0004));
        check("inv_other_noar", 32'(arvalid), 32'd0);

        // Matching invalidate forces a refill, served slowly
        ibus_inv = 1'b1; ibus_inv_addr = 32'hbfc0_0000;
        tick;
        ibus_inv = 1'b0;
        request(32'hbfc0_0000);
        check("inv_miss_arvalid", 32'(arvalid), 32'd1);
        check("inv_miss_valid", 32'(ibus_valid), 32'd0);
        do_fill(32'hbfc0_0000, 5, 1'b1, 1'b0);
        check("slow_rddata", ibus_rddata, mem_word(32'hbfc0_0000));
        tick;
        request(32'hbfc0_0010);
        check("slow_hit_valid", 32'(ibus_valid), 32'd1);
        check("slow_hit_rddata", ibus_rddata, mem_word(32'hbfc0_0010));

        // Reset in the middle of a burst
        request(32'hbfc0_0040);
        check("mid_arvalid", 32'(arvalid), 32'd1);
        arready = 1'b1;
        tick;
        arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rvalid = 1'b1;
            rdata  = mem_word(32'hbfc0_0040 + 32'(4 * i));
            tick;
        end
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(ibus_ready), 32'd1);
        check("midrst_valid", 32'(ibus_valid), 32'd0);
        check("midrst_rready", 32'(rready), 32'd0);
        check("midrst_arvalid", 32'(arvalid), 32'd0);
        tick;
        rst    = 1'b0;
        rvalid = 1'b0;
        tick;
        request(32'hbfc0_0000);
        check("postrst_miss", 32'(arvalid), 32'd1);

        // Invalidate racing the last beat still delivers the word but leaves the line invalid
        do_fill(32'hbfc0_0000, 0, 1'b0, 1'b1);
        check("race_rddata", ibus_rddata, mem_word(32'hbfc0_0000));
        tick;
        request(32'hbfc0_0000);
        check("race_miss_arvalid", 32'(arvalid), 32'd1);
        check("race_miss_valid", 32'(ibus_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
